// File: rtl/imem_responder_if.sv
// ---------------------------------------------------------------------------
// imem_responder_if
// Bundles the core fetch port and the byte-serial program loader port of
// imem_responder.
//   master : core + loader side (drives fetch address/enable and load bytes)
//   slave  : imem_responder (returns instruction, fault, ready, hold, status)
// Signals:
//   inst_addr/inst_ena        fetch request from the core
//   inst/fetch_fault          fetch response (combinational)
//   load_start/valid/byte/last program loader stream
//   load_ready                loader accepts a byte this cycle
//   cpu_hold                  core must stay held while not running
//   load_err/words_loaded     loader status
// ---------------------------------------------------------------------------
interface imem_responder_if #(
  parameter int unsigned DEPTH_WORDS = 1024
);
  localparam int unsigned CW = $clog2(DEPTH_WORDS) + 1;

  logic [63:0]   inst_addr;
  logic          inst_ena;
  logic [31:0]   inst;
  logic          fetch_fault;
  logic          load_start;
  logic          load_valid;
  logic [7:0]    load_byte;
  logic          load_last;
  logic          load_ready;
  logic          cpu_hold;
  logic          load_err;
  logic [CW-1:0] words_loaded;

  modport master (
    output inst_addr, inst_ena, load_start, load_valid, load_byte, load_last,
    input  inst, fetch_fault, load_ready, cpu_hold, load_err, words_loaded
  );

  modport slave (
    input  inst_addr, inst_ena, load_start, load_valid, load_byte, load_last,
    output inst, fetch_fault, load_ready, cpu_hold, load_err, words_loaded
  );
endinterface

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
// Instruction memory beside the core: answers fetches combinationally from an
// internal RAM and fills that RAM through a byte-serial valid/ready loader.
// The core is held (cpu_hold) until a load completes.
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   imem_if  slave side of imem_responder_if (fetch + loader + status)
// ---------------------------------------------------------------------------
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter logic [31:0] NOP_INST    = 32'h00000013,
  parameter bit          BOOT_LOAD   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  imem_responder_if.slave    imem_if
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_RESET = BOOT_LOAD ? S_IDLE : S_RUN;

  logic [1:0]    state_q,        state_d;
  logic [CW-1:0] ptr_q,          ptr_d;
  logic [1:0]    byte_cnt_q,     byte_cnt_d;
  logic [31:0]   asm_word_q,     asm_word_d;
  logic          load_err_q,     load_err_d;
  logic [CW-1:0] words_loaded_q, words_loaded_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          we_c;
  logic [AW-1:0] waddr_c;
  logic [31:0]   wdata_c;

  // ---------------------------------------------------------------------
  // Fetch path: zero-latency read, NOP whenever the core must not see RAM
  // ---------------------------------------------------------------------
  logic [61:0] off_word_c;
  logic        misaligned_c;
  logic        below_base_c;
  logic        out_of_range_c;
  logic        fault_c;
  logic        fetch_hit_c;

  // Word offset from BASE_ADDR; wraps for addresses below base, which are
  // flagged separately so the wrapped value never reaches the RAM.
  assign off_word_c     = 62'((imem_if.inst_addr - BASE_ADDR) >> 2);
  assign misaligned_c   = imem_if.inst_addr[1:0] != 2'b00;
  assign below_base_c   = imem_if.inst_addr < BASE_ADDR;
  assign out_of_range_c = off_word_c >= 62'(DEPTH_WORDS);
  assign fault_c        = imem_if.inst_ena &
                          (misaligned_c | below_base_c | out_of_range_c);
  assign fetch_hit_c    = (state_q == S_RUN) & imem_if.inst_ena & ~fault_c;

  assign imem_if.fetch_fault = fault_c;
  assign imem_if.inst        = fetch_hit_c ? mem_q[off_word_c[AW-1:0]]
                                           : NOP_INST;

  // ---------------------------------------------------------------------
  // Loader handshake
  // ---------------------------------------------------------------------
  logic        load_ready_c;
  logic        accept_c;
  logic        full_c;
  logic [31:0] merged_c;

  // load_start owns its cycle: no byte is taken while a (re)start happens.
  assign load_ready_c = (state_q == S_LOAD) & ~imem_if.load_start;
  assign accept_c     = load_ready_c & imem_if.load_valid;
  assign full_c       = ptr_q == DEPTH_CNT;
  // Incoming byte merged into the partially assembled little-endian word.
  assign merged_c     = asm_word_q |
                        (32'(imem_if.load_byte) << {byte_cnt_q, 3'b000});

  assign imem_if.load_ready   = load_ready_c;
  assign imem_if.cpu_hold     = state_q != S_RUN;
  assign imem_if.load_err     = load_err_q;
  assign imem_if.words_loaded = words_loaded_q;

  // Next-state and loader datapath
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    byte_cnt_d     = byte_cnt_q;
    asm_word_d     = asm_word_q;
    load_err_d     = load_err_q;
    words_loaded_d = words_loaded_q;
    we_c           = 1'b0;
    waddr_c        = ptr_q[AW-1:0];
    wdata_c        = merged_c;

    if (imem_if.load_start) begin
      // Start or restart: every state goes back to word 0 with clean status.
      state_d        = S_LOAD;
      ptr_d          = '0;
      byte_cnt_d     = '0;
      asm_word_d     = '0;
      load_err_d     = 1'b0;
      words_loaded_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_RUN: begin
        end
        S_LOAD: begin
          if (accept_c) begin
            if (full_c) begin
              // Memory full: drop the byte but keep accepting so that
              // load_last can still close the image.
              load_err_d = 1'b1;
            end else if ((byte_cnt_q == 2'd3) || imem_if.load_last) begin
              // Word complete (or image ends early): unfilled bytes are 0.
              we_c           = ~rst;
              ptr_d          = ptr_q + CW'(1);
              words_loaded_d = words_loaded_q + CW'(1);
              byte_cnt_d     = '0;
              asm_word_d     = '0;
            end else begin
              asm_word_d = merged_c;
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
            if (imem_if.load_last) begin
              state_d = S_RUN;
            end
          end
        end
        default: begin
          state_d = S_RESET;
        end
      endcase
    end
  end

  // State and loader registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_RESET;
      ptr_q          <= '0;
      byte_cnt_q     <= '0;
      asm_word_q     <= '0;
      load_err_q     <= 1'b0;
      words_loaded_q <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      byte_cnt_q     <= byte_cnt_d;
      asm_word_q     <= asm_word_d;
      load_err_q     <= load_err_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  // Instruction RAM: contents survive reset
  always_ff @(posedge clk) begin
    if (we_c) begin
      mem_q[waddr_c] <= wdata_c;
    end
  end

endmodule
